// File: rtl/round_key_gen.sv
// Sequential AES-128 key schedule: loads a cipher key on start and issues
// round keys 0..10 over a valid/ready handshake, one key per accepted transfer.
module round_key_gen (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [0:3][0:3][7:0]   key_in,
    output logic [0:3][0:3][7:0]   round_key,
    output logic [3:0]             rk_round,
    output logic                   rk_valid,
    input  logic                   rk_ready,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'd10;

    // Row r holds S-box entries 16*r .. 16*r+15, lowest index leftmost.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        sbox = SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // SubWord(RotWord(w)) with the round constant folded into the top byte.
    function automatic logic [0:3][7:0] sub_rot_word(input logic [0:3][7:0] w,
                                                     input logic [7:0]      rc);
        sub_rot_word[0] = sbox(w[1]) ^ rc;
        sub_rot_word[1] = sbox(w[2]);
        sub_rot_word[2] = sbox(w[3]);
        sub_rot_word[3] = sbox(w[0]);
    endfunction

    state_t                  state_r;
    state_t                  state_nx_s;
    logic [0:3][0:3][7:0]    key_r;
    logic [0:3][0:3][7:0]    key_nx_s;
    logic [0:3][7:0]         temp_s;
    logic [3:0]              round_r;
    logic [7:0]              rcon_r;
    logic                    valid_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    accept_s;
    logic                    hs_s;
    logic                    last_s;

    assign accept_s = (state_r == ST_IDLE) && start;
    assign hs_s     = (state_r == ST_ISSUE) && valid_r && rk_ready;
    assign last_s   = (round_r == LAST_ROUND);

    // Next round key derived from the current key register.
    always_comb begin
        temp_s      = sub_rot_word(key_r[3], rcon_r);
        key_nx_s    = key_r;
        key_nx_s[0] = key_r[0] ^ temp_s;
        key_nx_s[1] = key_r[1] ^ key_nx_s[0];
        key_nx_s[2] = key_r[2] ^ key_nx_s[1];
        key_nx_s[3] = key_r[3] ^ key_nx_s[2];
    end

    // Next-state logic; start is only honoured from IDLE.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nx_s = ST_ISSUE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (hs_s && last_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_ISSUE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Registered status flags, decoded from the upcoming state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            valid_r <= (state_nx_s == ST_ISSUE);
            busy_r  <= (state_nx_s == ST_ISSUE);
            done_r  <= hs_s && last_s;
        end
    end

    // Key register, round counter and rcon advance together on each handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_r   <= '0;
            round_r <= 4'd0;
            rcon_r  <= 8'h01;
        end else if (accept_s) begin
            key_r   <= key_in;
            round_r <= 4'd0;
            rcon_r  <= 8'h01;
        end else if (hs_s && !last_s) begin
            key_r   <= key_nx_s;
            round_r <= round_r + 4'd1;
            rcon_r  <= xtime(rcon_r);
        end else begin
            key_r   <= key_r;
            round_r <= round_r;
            rcon_r  <= rcon_r;
        end
    end

    assign round_key = key_r;
    assign rk_round  = round_r;
    assign rk_valid  = valid_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_round_key_gen.sv
// Directed bench for round_key_gen: table of FIPS-197 round keys plus
// backpressure, start-while-busy and asynchronous-reset sequences.
module tb_round_key_gen;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic [127:0] round_key;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic         rk_ready;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;

    logic [127:0] a1  [0:10];
    logic [127:0] cap [0:10];

    typedef struct {
        logic [127:0] key;
        int           rnd;
        logic [127:0] exp;
    } vec_t;

    vec_t vt [0:13];

    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    round_key_gen dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .round_key (round_key),
        .rk_round  (rk_round),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full schedule with ready held high, capturing every issued key.
    task automatic run_full(input logic [127:0] k);
        start    = 1'b1;
        key_in   = k;
        rk_ready = 1'b1;
        tick();
        start  = 1'b0;
        key_in = ~k;
        for (int i = 0; i < 11; i++) begin
            check("sched_valid", 128'(rk_valid), 128'd1);
            check("sched_round", 128'(rk_round), 128'(i));
            check("sched_done_low", 128'(done), 128'd0);
            cap[i] = round_key;
            tick();
        end
        check("done_pulse", 128'(done), 128'd1);
        check("done_valid_low", 128'(rk_valid), 128'd0);
        check("done_busy_low", 128'(busy), 128'd0);
        tick();
        check("done_one_cycle", 128'(done), 128'd0);
    endtask

    initial begin
        int  k;
        bit  fin;
        bit  rdy;

        a1[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        a1[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        a1[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        a1[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        a1[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        a1[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        a1[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        a1[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        a1[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        a1[9]  = 128'hac7766f319fadc2128d12941575c006e;
        a1[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        for (int i = 0; i < 11; i++) begin
            vt[i] = '{key: a1[0], rnd: i, exp: a1[i]};
        end
        vt[11] = '{key: 128'd0, rnd: 0,  exp: 128'd0};
        vt[12] = '{key: 128'd0, rnd: 1,  exp: ZERO_R1};
        vt[13] = '{key: 128'd0, rnd: 10, exp: ZERO_R10};

        rst      = 1'b0;
        start    = 1'b0;
        rk_ready = 1'b0;
        key_in   = 128'd0;
        #2;
        check("rst_valid", 128'(rk_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_round", 128'(rk_round), 128'd0);
        check("rst_key", round_key, 128'd0);
        #10;
        rst = 1'b1;
        tick();

        for (int v = 0; v < 14; v++) begin
            run_full(vt[v].key);
            check($sformatf("vec%0d_round%0d", v, vt[v].rnd), cap[vt[v].rnd], vt[v].exp);
        end

        // Backpressure: ready toggles, keys must hold and never skip or repeat.
        start    = 1'b1;
        key_in   = a1[0];
        rk_ready = 1'b0;
        tick();
        start  = 1'b0;
        key_in = 128'd0;
        k   = 0;
        fin = 1'b0;
        check("bp_round0_key", round_key, a1[0]);
        for (int c = 0; c < 300 && !fin; c++) begin
            rdy = (c < 2) ? c[0] : 1'($urandom_range(0, 1));
            rk_ready = rdy;
            tick();
            if (rdy) begin
                if (k == 10) begin
                    fin = 1'b1;
                    check("bp_done", 128'(done), 128'd1);
                    check("bp_done_valid", 128'(rk_valid), 128'd0);
                end else begin
                    k++;
                    check("bp_adv_round", 128'(rk_round), 128'(k));
                    check("bp_adv_key", round_key, a1[k]);
                    check("bp_adv_valid", 128'(rk_valid), 128'd1);
                end
            end else begin
                check("bp_hold_round", 128'(rk_round), 128'(k));
                check("bp_hold_key", round_key, a1[k]);
                check("bp_hold_valid", 128'(rk_valid), 128'd1);
                check("bp_hold_done", 128'(done), 128'd0);
            end
        end
        rk_ready = 1'b0;
        check("bp_finished", 128'(fin), 128'd1);
        tick();
        check("bp_done_once", 128'(done), 128'd0);

        // Start while busy (round 4 and on the final handshake) is ignored.
        start    = 1'b1;
        key_in   = a1[0];
        rk_ready = 1'b1;
        tick();
        for (int i = 0; i < 11; i++) begin
            check("busy_round", 128'(rk_round), 128'(i));
            check("busy_key", round_key, a1[i]);
            start  = (i == 4) || (i == 10);
            key_in = 128'd0;
            tick();
        end
        check("busy_final_start_ignored", 128'(rk_valid), 128'd0);
        check("busy_done", 128'(done), 128'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_valid", 128'(rk_valid), 128'd1);
        check("restart_round", 128'(rk_round), 128'd0);
        check("restart_key", round_key, 128'd0);
        tick();
        check("restart_r1", round_key, ZERO_R1);
        fin = 1'b0;
        for (int c = 0; c < 20 && !fin; c++) begin
            tick();
            fin = done;
        end
        check("restart_drained", 128'(fin), 128'd1);

        // Asynchronous reset in round 6, then a clean restart.
        start    = 1'b1;
        key_in   = a1[0];
        rk_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
        end
        check("pre_rst_round", 128'(rk_round), 128'd6);
        #3;
        rst = 1'b0;
        #1;
        check("arst_valid", 128'(rk_valid), 128'd0);
        check("arst_busy", 128'(busy), 128'd0);
        check("arst_done", 128'(done), 128'd0);
        check("arst_round", 128'(rk_round), 128'd0);
        check("arst_key", round_key, 128'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        tick();
        check("post_rst_idle0", 128'(rk_valid), 128'd0);
        tick();
        check("post_rst_idle1", 128'(busy), 128'd0);
        run_full(a1[0]);
        for (int i = 0; i < 11; i++) begin
            check($sformatf("post_rst_round%0d", i), cap[i], a1[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
